mul4_product_accumulator: RTL and testbench
===========================================

// Module: mul4_product_accumulator
// PURPOSE
//  Downstream consumer of the 4-bit shift-add multiplier's 8-bit product. Sums a fixed-size group of
//  N_TERMS products into an accumulator, then presents the group total on a valid/ready output.
//  Forms the accumulate half of a multiply-accumulate datapath; the multiplier pulses prod_valid
//  once per finished product.
// PARAMETERS
//  PROD_W   8   width of incoming product
//  ACC_W    10  accumulator/output width (>= PROD_W)
//  N_TERMS  4   products per group (>= 1)
//  CNT_W    3   term counter width; must hold values 0..N_TERMS
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  clear       in   1        synchronous abort of current group
//  prod_valid  in   1        product available from multiplier
//  prod_ready  out  1        block accepts product this cycle
//  prod        in   PROD_W   unsigned product
//  acc_valid   out  1        group total valid
//  acc_ready   in   1        downstream takes total
//  acc_out     out  ACC_W    group total
//  acc_count   out  CNT_W    products accepted in current group
//  overflow    out  1        sticky per group: a sum exceeded 2^ACC_W-1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=ACCUM, acc_out=0, acc_count=0, overflow=0, acc_valid=0, prod_ready=0
//    while rst_n=0; prod_ready=1 from first clock after release.
//  - States: ACCUM (prod_ready=1, acc_valid=0); HOLD (prod_ready=0, acc_valid=1).
//  - ACCUM: on prod_valid&&prod_ready: acc_out <= acc_out + zero-extended prod; acc_count++;
//    overflow |= carry-out. When accepted term is the N_TERMS-th -> HOLD next cycle
//    (1-cycle latency, last product to acc_valid).
//  - HOLD: acc_out, acc_count(=N_TERMS), overflow stable. On acc_ready -> ACCUM with acc_out=0,
//    acc_count=0, overflow=0. prod_valid ignored in HOLD; upstream must hold its product.
//  - acc_valid drops cycle after handshake; no back-to-back bypass (one bubble per group).
//  - clear=1: next edge forces ACCUM, acc_out=0, acc_count=0, overflow=0, acc_valid=0. Priority over
//    product accept and acc_ready; a product presented same cycle is discarded (prod_ready stays 1).
//  - Arithmetic unsigned; without saturation, sum wraps modulo 2^ACC_W.
//  - N_TERMS=1: every accepted product goes straight to HOLD.
//  - Reset mid-group or in HOLD: pending total lost, outputs to reset values immediately.
// CONFIGURATION
//  MUL4_ACC_SATURATE_EN defined: on carry-out acc_out clamps to 2^ACC_W-1 and remains there for rest
//    of group; overflow still set.
//  Not defined: modulo wrap; overflow flag only.
// STRUCTURE
//  Package mul4_acc_pkg: state typedef {ACCUM, HOLD}, default width constants.
//  Sub-module mul4_acc_add: combinational ACC_W adder returning sum and carry, applies clamp under
//  MUL4_ACC_SATURATE_EN. Top holds FSM, counter and registers.
// TESTING
//  1 Basic group: products 143,40,100,200 one per cycle, acc_ready=1 -> acc_valid one cycle
//    after 4th accept, acc_out=483, overflow=0.
//  2 Backpressure: same group, acc_ready=0 for 5 cycles -> acc_out=483 stable, prod_ready=0;
//    prod_valid=1 with 77 not accepted until after handshake.
//  3 Overflow (ACC_W=9): 4x143 -> overflow=1; acc_out=60 without macro, 511 with
//    MUL4_ACC_SATURATE_EN.
//  4 Clear mid-group: 2 products (50,60) then clear with prod=99 valid -> acc_count=0, acc_out=0,
//    99 dropped; next 4x10 -> 40.
//  5 Async reset in HOLD: drop rst_n between edges -> acc_valid=0, acc_out=0 immediately.
//  6 Gapped input: products 11,13,26,10 with random idle cycles -> acc_out=60, acc_count tracks 1..4.

Source files
------------

// File: rtl/mul4_acc_pkg.sv
// -----------------------------------------------------------------------------
// mul4_acc_pkg
//   Shared types and default widths for the product accumulator that sits
//   behind the 4-bit shift-add multiplier.
//
//   Contents:
//     PROD_W_DEF / ACC_W_DEF / N_TERMS_DEF / CNT_W_DEF : default parameters
//     acc_state_e : accumulator FSM state (ACCUM gathers terms, HOLD offers
//                   the group total downstream)
// -----------------------------------------------------------------------------
package mul4_acc_pkg;

  localparam int PROD_W_DEF  = 8;   // multiplier product width
  localparam int ACC_W_DEF   = 10;  // accumulator / total width
  localparam int N_TERMS_DEF = 4;   // products summed per group
  localparam int CNT_W_DEF   = 3;   // must hold 0..N_TERMS

  typedef enum logic {
    ACCUM = 1'b0,  // accepting products, prod_ready=1
    HOLD  = 1'b1   // presenting total, acc_valid=1
  } acc_state_e;

endpackage : mul4_acc_pkg

// File: rtl/mul4_acc_add.sv
// -----------------------------------------------------------------------------
// mul4_acc_add
//   Combinational ACC_W-bit adder: running total plus zero-extended product.
//   Reports the carry-out so the caller can keep a sticky overflow flag.
//
//   Configuration macro: MUL4_ACC_SATURATE_EN
//     defined   : on carry-out the sum clamps to 2^ACC_W-1
//     undefined : sum wraps modulo 2^ACC_W
//
//   Ports:
//     acc   in  ACC_W   current accumulator value
//     prod  in  PROD_W  unsigned product to add
//     sum   out ACC_W   next accumulator value (wrapped or clamped)
//     carry out 1       the true sum exceeded 2^ACC_W-1
// -----------------------------------------------------------------------------
module mul4_acc_add
  import mul4_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  // One extra bit captures the carry-out of the unsigned add.
  logic [ACC_W:0] full_sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    full_sum = '0;
    sum      = '0;
    carry    = 1'b0;

    full_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    carry    = full_sum[ACC_W];
`ifdef MUL4_ACC_SATURATE_EN
    // Once the clamp engages, acc sits at all-ones, so any further non-zero
    // product carries again and the value stays pinned for the rest of the group.
    sum      = carry ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    sum      = full_sum[ACC_W-1:0];
`endif
  end

endmodule : mul4_acc_add

// File: rtl/mul4_product_accumulator.sv
// -----------------------------------------------------------------------------
// mul4_product_accumulator
//   Accumulate half of a multiply-accumulate datapath. Sums groups of N_TERMS
//   unsigned products arriving on a valid/ready input and presents each group
//   total on a valid/ready output. One bubble separates consecutive groups:
//   the total is dropped the cycle after it is taken, and only then does
//   prod_ready return.
//
//   Configuration macro: MUL4_ACC_SATURATE_EN (clamp instead of wrap; see
//   mul4_acc_add).
//
//   Ports:
//     clk         in   1       rising-edge clock
//     rst_n       in   1       asynchronous active-low reset
//     clear       in   1       synchronous abort of the current group
//     prod_valid  in   1       product available from multiplier
//     prod_ready  out  1       product accepted this cycle when valid
//     prod        in   PROD_W  unsigned product
//     acc_valid   out  1       group total valid
//     acc_ready   in   1       downstream takes the total
//     acc_out     out  ACC_W   running / group total
//     acc_count   out  CNT_W   products accepted in the current group
//     overflow    out  1       sticky per group: some sum exceeded 2^ACC_W-1
// -----------------------------------------------------------------------------
module mul4_product_accumulator
  import mul4_acc_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_count,
  output logic              overflow
);

  // Count value held while the final term of a group is being accepted.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  acc_state_e       state;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             accept;

  mul4_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc   (acc_out),
    .prod  (prod),
    .sum   (sum),
    .carry (carry)
  );

  // prod_ready is registered and low for the first cycle after reset release,
  // so it must gate acceptance alongside the state.
  assign accept = (state == ACCUM) && prod_valid && prod_ready;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc_out    <= '0;
      acc_count  <= '0;
      overflow   <= 1'b0;
      acc_valid  <= 1'b0;
      prod_ready <= 1'b0;
    end else if (clear) begin
      // Abort wins over both handshakes; a product offered this cycle is lost.
      state      <= ACCUM;
      acc_out    <= '0;
      acc_count  <= '0;
      overflow   <= 1'b0;
      acc_valid  <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          prod_ready <= 1'b1;
          if (accept) begin
            acc_out   <= sum;
            acc_count <= acc_count + CNT_W'(1);
            overflow  <= overflow | carry;
            if (acc_count == LAST_IDX) begin
              state      <= HOLD;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
            end
          end
        end
        HOLD: begin
          // Total, count and flag stay frozen until downstream takes them.
          if (acc_ready) begin
            state      <= ACCUM;
            acc_out    <= '0;
            acc_count  <= '0;
            overflow   <= 1'b0;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ACCUM;
          acc_out    <= '0;
          acc_count  <= '0;
          overflow   <= 1'b0;
          acc_valid  <= 1'b0;
          prod_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : mul4_product_accumulator

// File: tb/tb_mul4_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mul4_product_accumulator
//   Directed bench for mul4_product_accumulator. Three instances share clk and
//   rst_n: the default configuration (ACC_W=10, N_TERMS=4), a narrow one
//   (ACC_W=9) to reach overflow, and a single-term one (N_TERMS=1).
//   Expected totals follow MUL4_ACC_SATURATE_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mul4_product_accumulator;

  logic clk;
  logic rst_n;

  // Default instance
  logic       clear, prod_valid, prod_ready, acc_valid, acc_ready, overflow;
  logic [7:0] prod;
  logic [9:0] acc_out;
  logic [2:0] acc_count;

  // ACC_W = 9 instance
  logic       clear9, prod_valid9, prod_ready9, acc_valid9, acc_ready9, overflow9;
  logic [7:0] prod9;
  logic [8:0] acc_out9;
  logic [2:0] acc_count9;

  // N_TERMS = 1 instance
  logic       clear1, prod_valid1, prod_ready1, acc_valid1, acc_ready1, overflow1;
  logic [7:0] prod1;
  logic [9:0] acc_out1;
  logic [0:0] acc_count1;

  int vectors = 0;
  int errors  = 0;

  mul4_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out),
    .acc_count(acc_count), .overflow(overflow)
  );

  mul4_product_accumulator #(.ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear9),
    .prod_valid(prod_valid9), .prod_ready(prod_ready9), .prod(prod9),
    .acc_valid(acc_valid9), .acc_ready(acc_ready9), .acc_out(acc_out9),
    .acc_count(acc_count9), .overflow(overflow9)
  );

  mul4_product_accumulator #(.N_TERMS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1),
    .prod_valid(prod_valid1), .prod_ready(prod_ready1), .prod(prod1),
    .acc_valid(acc_valid1), .acc_ready(acc_ready1), .acc_out(acc_out1),
    .acc_count(acc_count1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product for a single cycle on the default instance.
  task automatic push(input logic [7:0] p);
    prod       = p;
    prod_valid = 1'b1;
    step();
    prod_valid = 1'b0;
  endtask

  logic [7:0] grp [4];
  int         sums [4];
  logic [9:0] exp_ovf_total;
  int         idle;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
    clear9 = 1'b0; prod_valid9 = 1'b0; prod9 = '0; acc_ready9 = 1'b0;
    clear1 = 1'b0; prod_valid1 = 1'b0; prod1 = '0; acc_ready1 = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_acc_out",    acc_out,    0);
    check("rst_acc_count",  acc_count,  0);
    check("rst_overflow",   overflow,   0);
    check("rst_acc_valid",  acc_valid,  0);
    check("rst_prod_ready", prod_ready, 0);
    step();
    step();
    check("rst_held_prod_ready", prod_ready, 0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_prod_ready", prod_ready, 1);

    // ---------------- 1: basic group ----------------
    grp[0] = 8'd143; grp[1] = 8'd40; grp[2] = 8'd100; grp[3] = 8'd200;
    sums[0] = 143;   sums[1] = 183;  sums[2] = 283;   sums[3] = 483;
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(grp[i]);
      check("t1_sum",   acc_out,   sums[i]);
      check("t1_count", acc_count, i + 1);
    end
    check("t1_acc_valid",  acc_valid,  1);
    check("t1_overflow",   overflow,   0);
    check("t1_prod_ready", prod_ready, 0);
    step();
    check("t1_valid_drop", acc_valid,  0);
    check("t1_acc_zero",   acc_out,    0);
    check("t1_cnt_zero",   acc_count,  0);
    check("t1_ready_back", prod_ready, 1);

    // ---------------- 2: backpressure ----------------
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(grp[i]);
    prod       = 8'd77;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_total", acc_out,    483);
      check("t2_hold_ready", prod_ready, 0);
      check("t2_hold_valid", acc_valid,  1);
      check("t2_hold_count", acc_count,  4);
      step();
    end
    acc_ready = 1'b1;
    step();
    check("t2_handshake_acc", acc_out,   0);
    check("t2_handshake_vld", acc_valid, 0);
    acc_ready = 1'b0;
    step();
    check("t2_77_taken", acc_out,   77);
    check("t2_77_count", acc_count, 1);
    prod_valid = 1'b0;
    clear      = 1'b1;
    step();
    clear = 1'b0;
    check("t2_clear_acc", acc_out, 0);

    // ---------------- 3: overflow on ACC_W=9 ----------------
`ifdef MUL4_ACC_SATURATE_EN
    exp_ovf_total = 10'd511;
`else
    exp_ovf_total = 10'd60;
`endif
    prod9 = 8'd143;
    for (int i = 0; i < 4; i++) begin
      prod_valid9 = 1'b1;
      step();
      prod_valid9 = 1'b0;
      check("t3_overflow", overflow9, (i == 3) ? 1 : 0);
      if (i == 2) check("t3_sum3", acc_out9, 429);
    end
    check("t3_total", acc_out9,   exp_ovf_total);
    check("t3_valid", acc_valid9, 1);
    acc_ready9 = 1'b1;
    step();
    acc_ready9 = 1'b0;
    check("t3_ovf_cleared", overflow9, 0);

    // ---------------- 4: clear mid-group ----------------
    acc_ready = 1'b1;
    push(8'd50);
    push(8'd60);
    check("t4_partial", acc_out,   110);
    check("t4_pcount",  acc_count, 2);
    clear      = 1'b1;
    prod       = 8'd99;
    prod_valid = 1'b1;
    step();
    clear      = 1'b0;
    prod_valid = 1'b0;
    check("t4_clr_count", acc_count,  0);
    check("t4_clr_acc",   acc_out,    0);
    check("t4_clr_ready", prod_ready, 1);
    check("t4_clr_valid", acc_valid,  0);
    for (int i = 0; i < 4; i++) push(8'd10);
    check("t4_total", acc_out,   40);
    check("t4_valid", acc_valid, 1);
    step();
    check("t4_drop", acc_valid, 0);

    // ---------------- 5: async reset in HOLD ----------------
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'd10);
    check("t5_in_hold", acc_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", acc_valid,  0);
    check("t5_rst_acc",   acc_out,    0);
    check("t5_rst_count", acc_count,  0);
    check("t5_rst_ready", prod_ready, 0);
    #2 rst_n = 1'b1;
    step();
    check("t5_ready_back", prod_ready, 1);

    // ---------------- 6: gapped input ----------------
    grp[0] = 8'd11; grp[1] = 8'd13; grp[2] = 8'd26; grp[3] = 8'd10;
    for (int i = 0; i < 4; i++) begin
      idle = int'($urandom_range(0, 3));
      for (int k = 0; k < idle; k++) begin
        step();
        check("t6_idle_count", acc_count, i);
      end
      push(grp[i]);
      check("t6_count", acc_count, i + 1);
    end
    check("t6_total", acc_out,   60);
    check("t6_valid", acc_valid, 1);
    acc_ready = 1'b1;
    step();
    check("t6_drop", acc_valid, 0);

    // ---------------- 7: N_TERMS = 1 ----------------
    prod1       = 8'd200;
    prod_valid1 = 1'b1;
    step();
    prod_valid1 = 1'b0;
    check("t7_valid", acc_valid1,  1);
    check("t7_total", acc_out1,    200);
    check("t7_count", acc_count1,  1);
    check("t7_ready", prod_ready1, 0);
    acc_ready1 = 1'b1;
    step();
    check("t7_drop", acc_valid1, 0);
    check("t7_zero", acc_out1,   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_mul4_product_accumulator
